// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Operands arrive on a valid/ready handshake; the result is held until the consumer accepts it.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, a_sh_next;
  logic [WIDTH-1:0] b_sh, b_sh_next;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             borrow, borrow_next;
  logic             a_msb, a_msb_next;
  logic             b_msb, b_msb_next;
  logic             bout_next, ovf_next, done_valid_next;
  logic             start_ready_next, busy_next;
  logic             d_bit, br_cell;
  logic [WIDTH:0]   diff_ins;

  // Full-subtractor cell on the current LSBs and the running borrow
  always_comb begin
    d_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
    br_cell  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow) | (b_sh[0] & borrow);
    diff_ins = {d_bit, diff};
  end

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    a_sh_next       = a_sh;
    b_sh_next       = b_sh;
    diff_next       = diff;
    cnt_next        = cnt;
    borrow_next     = borrow;
    a_msb_next      = a_msb;
    b_msb_next      = b_msb;
    bout_next       = bout;
    ovf_next        = ovf;
    done_valid_next = done_valid;

    case (state)
      IDLE: begin
        if (start_valid && start_ready) begin
          state_next  = SHIFT;
          a_sh_next   = a;
          b_sh_next   = b;
          borrow_next = bin;
          cnt_next    = '0;
          a_msb_next  = a[WIDTH-1];
          b_msb_next  = b[WIDTH-1];
        end
      end
      SHIFT: begin
        a_sh_next   = a_sh >> 1;
        b_sh_next   = b_sh >> 1;
        borrow_next = br_cell;
        diff_next   = diff_ins[WIDTH:1];
        cnt_next    = cnt + CW'(1);
        // Last bit: the fresh d_bit becomes the result sign
        if (cnt == CW'(WIDTH - 1)) begin
          state_next      = DONE;
          bout_next       = br_cell;
          ovf_next        = (a_msb != b_msb) && (d_bit != a_msb);
          done_valid_next = 1'b1;
        end
      end
      DONE: begin
        if (done_valid && done_ready) begin
          state_next      = IDLE;
          done_valid_next = 1'b0;
        end
      end
      default: begin
        state_next      = IDLE;
        done_valid_next = 1'b0;
      end
    endcase

    start_ready_next = (state_next == IDLE);
    busy_next        = (state_next == SHIFT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      diff        <= '0;
      cnt         <= '0;
      borrow      <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      bout        <= 1'b0;
      ovf         <= 1'b0;
      done_valid  <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      a_sh        <= a_sh_next;
      b_sh        <= b_sh_next;
      diff        <= diff_next;
      cnt         <= cnt_next;
      borrow      <= borrow_next;
      a_msb       <= a_msb_next;
      b_msb       <= b_msb_next;
      bout        <= bout_next;
      ovf         <= ovf_next;
      done_valid  <= done_valid_next;
      start_ready <= start_ready_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance for directed/random/protocol scenarios
// and a 4-bit instance swept exhaustively against an integer-arithmetic model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       sv8, sr8, bin8, bout8, ovf8, dv8, dr8, busy8;
  logic [7:0] a8, b8, diff8;
  logic       sv4, sr4, bin4, bout4, ovf4, dv4, dr4, busy4;
  logic [3:0] a4, b4, diff4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .ovf(ovf8),
    .done_valid(dv8), .done_ready(dr8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .ovf(ovf4),
    .done_valid(dv4), .done_ready(dr4), .busy(busy4)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  task automatic model(input int w, input int av, input int bv, input int bi,
                       output int d, output int bo, output int ov);
    int u, sa, sb, s;
    u  = av - bv - bi;
    d  = u & ((1 << w) - 1);
    bo = (u < 0) ? 1 : 0;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    s  = sa - sb - bi;
    ov = (s > (1 << (w - 1)) - 1 || s < -(1 << (w - 1))) ? 1 : 0;
  endtask

  // One full 8-bit operation from IDLE through the done handshake back to IDLE
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    checks++;
    if (sr8 !== 1'b1) begin
      failures++;
      $display("FAIL %s start_ready_idle got=%b exp=1", tag, sr8);
    end
    a8 = av; b8 = bv; bin8 = bi; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (dv8 !== 1'b0 || busy8 !== 1'b1 || sr8 !== 1'b0) begin
      failures++;
      $display("FAIL %s early_done dv=%b busy=%b sr=%b exp dv=0 busy=1 sr=0", tag, dv8, busy8, sr8);
    end
    @(posedge clk); #1;
    checks++;
    if (dv8 !== 1'b1 || diff8 !== ed || bout8 !== eb || ovf8 !== eo || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL %s result dv=%b diff=%h bout=%b ovf=%b busy=%b exp dv=1 diff=%h bout=%b ovf=%b busy=0",
               tag, dv8, diff8, bout8, ovf8, busy8, ed, eb, eo);
    end
    dr8 = 1'b1;
    @(posedge clk); #1;
    dr8 = 1'b0;
    checks++;
    if (dv8 !== 1'b0 || sr8 !== 1'b1 || diff8 !== ed || bout8 !== eb || ovf8 !== eo) begin
      failures++;
      $display("FAIL %s post_handshake dv=%b sr=%b diff=%h exp dv=0 sr=1 diff=%h", tag, dv8, sr8, diff8, ed);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sv8 = 0; a8 = 0; b8 = 0; bin8 = 0; dr8 = 0;
    sv4 = 0; a4 = 0; b4 = 0; bin4 = 0; dr4 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (dv8 !== 0 || diff8 !== 8'h00 || bout8 !== 0 || ovf8 !== 0 || busy8 !== 0 || sr8 !== 1) begin
      failures++;
      $display("FAIL reset8 dv=%b diff=%h bout=%b ovf=%b busy=%b sr=%b exp 0 00 0 0 0 1",
               dv8, diff8, bout8, ovf8, busy8, sr8);
    end
    checks++;
    if (dv4 !== 0 || diff4 !== 4'h0 || bout4 !== 0 || ovf4 !== 0 || busy4 !== 0 || sr4 !== 1) begin
      failures++;
      $display("FAIL reset4 dv=%b diff=%h bout=%b ovf=%b busy=%b sr=%b exp 0 0 0 0 0 1",
               dv4, diff4, bout4, ovf4, busy4, sr4);
    end
  endtask

  task automatic test_directed();
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "d_05_03");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "d_00_01");
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "d_80_01");
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "d_10_0F_b");
    op8(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, "d_00_FF_b");
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "d_7F_FF");
  endtask

  task automatic test_random();
    int d, bo, ov;
    logic [7:0] av, bv;
    logic bi;
    for (int i = 0; i < 20; i++) begin
      av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
      model(8, int'(av), int'(bv), int'(bi), d, bo, ov);
      op8(av, bv, bi, 8'(d), 1'(bo), 1'(ov), "random8");
    end
  endtask

  task automatic test_back_to_back();
    op8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "b2b_first");
    op8(8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_backpressure();
    int d, bo, ov;
    a8 = 8'h37; b8 = 8'h5A; bin8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22; bin8 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dv8 !== 1 || diff8 !== 8'hDD || bout8 !== 1 || ovf8 !== 0 || sr8 !== 0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d dv=%b diff=%h bout=%b ovf=%b sr=%b exp dv=1 diff=dd bout=1 ovf=0 sr=0",
                 i, dv8, diff8, bout8, ovf8, sr8);
      end
      @(posedge clk); #1;
    end
    dr8 = 1'b1;
    @(posedge clk); #1;
    dr8 = 1'b0;
    checks++;
    if (dv8 !== 0 || sr8 !== 1 || busy8 !== 0) begin
      failures++;
      $display("FAIL bp_release dv=%b sr=%b busy=%b exp 0 1 0", dv8, sr8, busy8);
    end
    @(posedge clk); #1;
    sv8 = 1'b0;
    checks++;
    if (busy8 !== 1 || sr8 !== 0) begin
      failures++;
      $display("FAIL bp_second_accept busy=%b sr=%b exp 1 0", busy8, sr8);
    end
    repeat (8) @(posedge clk);
    #1;
    model(8, 'h11, 'h22, 0, d, bo, ov);
    checks++;
    if (dv8 !== 1 || diff8 !== 8'(d) || bout8 !== 1'(bo) || ovf8 !== 1'(ov)) begin
      failures++;
      $display("FAIL bp_second_result dv=%b diff=%h bout=%b ovf=%b exp 1 %h %0d %0d",
               dv8, diff8, bout8, ovf8, 8'(d), bo, ov);
    end
    dr8 = 1'b1;
    @(posedge clk); #1;
    dr8 = 1'b0;
  endtask

  task automatic test_abort();
    int seen;
    a8 = 8'hC3; b8 = 8'h3C; bin8 = 1'b1; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dv8 !== 0 || diff8 !== 8'h00 || bout8 !== 0 || ovf8 !== 0 || busy8 !== 0 || sr8 !== 1) begin
      failures++;
      $display("FAIL abort_state dv=%b diff=%h bout=%b ovf=%b busy=%b sr=%b exp 0 00 0 0 0 1",
               dv8, diff8, bout8, ovf8, busy8, sr8);
    end
    seen = 0;
    dr8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dv8 !== 1'b0 || busy8 !== 1'b0) seen++;
    end
    dr8 = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_done bad_cycles=%0d exp 0", seen);
    end
  endtask

  task automatic test_exhaustive4();
    int d, bo, ov, c, got, lat;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          model(4, av, bv, bi, d, bo, ov);
          a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi); sv4 = 1'b1;
          @(posedge clk); #1;
          sv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
          got = 0; lat = 0;
          for (c = 1; c < 64 && got == 0; c++) begin
            @(posedge clk); #1;
            if (dv4 && lat == 0) lat = c;
            dr4 = 1'($urandom_range(0, 1));
            if (dv4 && dr4) begin
              got = 1;
              checks++;
              if (diff4 !== 4'(d) || bout4 !== 1'(bo) || ovf4 !== 1'(ov) || lat != 4) begin
                failures++;
                $display("FAIL exh4 a=%h b=%h bin=%0d diff=%h bout=%b ovf=%b lat=%0d exp %h %0d %0d lat=4",
                         4'(av), 4'(bv), bi, diff4, bout4, ovf4, lat, 4'(d), bo, ov);
              end
            end
          end
          if (got == 0) begin
            checks++;
            failures++;
            $display("FAIL exh4_timeout a=%h b=%h bin=%0d done_valid never accepted", 4'(av), 4'(bv), bi);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "timeout");
          end
          @(posedge clk); #1;
          dr4 = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
